// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64I instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // One instruction-queue entry handed to decode
  typedef struct packed {
    logic [31:0]         inst;
    logic [XLEN_DEF-1:0] pc;
    logic                misalign;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is the oldest stored entry.
// DEPTH must be a power of two and at least 2.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy tracking; flush discards everything at once
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// queues returned instructions for decode and squashes stale responses after
// a redirect. Optional macro FETCH_MISALIGN_TRAP_EN adds port id_misalign and
// turns misaligned redirect targets into a single trap entry.
module inst_fetch_unit import fetch_pkg::*; #(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            id_misalign
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   q_count, tag_count;
  logic            q_push, q_pop, q_flush, q_empty;
  logic            tag_push, tag_pop;
  logic            req_fire;
  entry_t          q_push_data, q_head;
  logic [XLEN-1:0] tag_head;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            halt_q, halt_d;
  logic            trap_q, trap_d;
`endif

  // Live tags plus responses still to be squashed equals requests in flight
  assign outstanding = tag_count + drop_q;
  assign q_empty     = (q_count == '0);

  // Credit-limited request issue; never in a redirect cycle
  assign imem_req_valid = !rst && !redirect_valid && ((outstanding + q_count) < CW'(FIFO_DEPTH))
`ifdef FETCH_MISALIGN_TRAP_EN
                          && !halt_q
`endif
                          ;
  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_valid && imem_req_ready;

  // Decode view of the queue head; misaligned trap entries always carry a NOP
  assign id_valid = !q_empty;
  assign id_inst  = (q_empty || q_head.misalign) ? NOP_INST : q_head.inst;
  assign id_pc    = q_empty ? '0 : XLEN'(q_head.pc);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign id_misalign = !q_empty && q_head.misalign;
`endif

  // Next-state: PC, squash count, queue control; redirect overrides everything
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    q_push      = 1'b0;
    q_pop       = 1'b0;
    q_flush     = 1'b0;
    tag_push    = 1'b0;
    tag_pop     = 1'b0;
    q_push_data = '{inst: imem_rsp_data, pc: XLEN_DEF'(tag_head), misalign: 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d      = halt_q;
    trap_d      = trap_q;
`endif
    if (redirect_valid) begin
      q_flush = 1'b1;
      drop_d  = outstanding - CW'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d   = redirect_pc;
        halt_d = 1'b1;
        trap_d = 1'b1;
      end else begin
        pc_d   = redirect_pc;
        halt_d = 1'b0;
        trap_d = 1'b0;
      end
`else
      pc_d = redirect_pc & ~XLEN'(3);
`endif
    end else begin
      q_pop = !q_empty && id_ready;
      if (req_fire) begin
        pc_d     = pc_q + XLEN'(4);
        tag_push = 1'b1;
      end
      if (imem_rsp_valid) begin
        if (state_q == DRAIN) begin
          drop_d = drop_q - CW'(1);
        end else begin
          q_push  = 1'b1;
          tag_pop = 1'b1;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // Trap entry once all stale responses are gone (nothing else in flight)
      if (trap_q && state_q == RUN) begin
        q_push      = 1'b1;
        q_push_data = '{inst: NOP_INST, pc: XLEN_DEF'(pc_q), misalign: 1'b1};
        trap_d      = 1'b0;
      end
`endif
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q  <= 1'b0;
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q  <= halt_d;
      trap_q  <= trap_d;
`endif
    end
  end

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .count     (q_count),
    .head      (q_head)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (pc_q),
    .pop       (tag_pop),
    .flush     (q_flush),
    .count     (tag_count),
    .head      (tag_head)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference model plus a fixed-latency
// memory model; honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .id_misalign    (id_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    bit          mis;
  } exp_t;
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  exp_t        eq[$];
  exp_t        popped[$];
  mreq_t       mq[$];
  logic [63:0] tags[$];
  int          m_out, m_drop;
  logic [63:0] m_pc;
  bit          m_halt, m_pend;
  int          errors = 0, checks = 0, cyc = 0, lat = 1;
  bit          last_req_valid;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_inst", {32'd0, id_inst}, {32'd0, NOP});
    chk("rst_id_pc", id_pc, 64'd0);
    rst = 1'b0;
    eq.delete(); tags.delete(); mq.delete(); popped.delete();
    m_out = 0; m_drop = 0; m_pc = 64'h0; m_halt = 1'b0; m_pend = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model
  task automatic step(input bit mr, input bit ir, input bit rv, input logic [63:0] rpc);
    bit          exp_rv, exp_v, rsp, fire, pop;
    logic [31:0] rdata;
    exp_t        e;
    imem_req_ready = mr;
    id_ready       = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
    rdata = imem_rsp_data;
    #1;
    exp_rv = !rv && (m_out + eq.size() < DEPTH) && !m_halt;
    exp_v  = eq.size() > 0;
    chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv});
    chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", {63'd0, id_valid}, {63'd0, exp_v});
    chk("id_inst", {32'd0, id_inst}, {32'd0, exp_v ? eq[0].inst : NOP});
    chk("id_pc", id_pc, exp_v ? eq[0].pc : 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("id_misalign", {63'd0, id_misalign}, {63'd0, exp_v ? eq[0].mis : 1'b0});
`endif
    last_req_valid = imem_req_valid;
    if (id_valid && ir && !rv) begin
      e.inst = id_inst; e.pc = id_pc; e.mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      e.mis = id_misalign;
`endif
      popped.push_back(e);
    end
    fire = exp_rv && mr;
    pop  = exp_v && ir;
    if (rsp) void'(mq.pop_front());
    if (rv) begin
      eq.delete(); tags.delete();
      m_out  = m_out - (rsp ? 1 : 0);
      m_drop = m_out;
      if (MIS_EN && rpc[1:0] != 2'b00) begin
        m_pc = rpc; m_halt = 1'b1; m_pend = 1'b1;
      end else begin
        m_pc = {rpc[63:2], 2'b00}; m_halt = 1'b0; m_pend = 1'b0;
      end
    end else begin
      if (pop) void'(eq.pop_front());
      if (m_pend && m_drop == 0) begin
        e.inst = NOP; e.pc = m_pc; e.mis = 1'b1;
        eq.push_back(e);
        m_pend = 1'b0;
      end
      if (rsp) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          e.inst = rdata; e.pc = tags.pop_front(); e.mis = 1'b0;
          eq.push_back(e);
        end
      end
      if (fire) begin
        tags.push_back(m_pc);
        mq.push_back('{addr: m_pc, due: cyc + lat});
        m_pc = m_pc + 64'd4;
        m_out++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    @(negedge clk);

    // Free-running fetch, latency 1
    do_reset();
    lat = 1;
    chk("t1_first_addr", imem_req_addr, 64'h0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("t1_pops", 64'(popped.size() >= 3), 64'd1);
    if (popped.size() >= 3) begin
      chk("t1_pc0", popped[0].pc, 64'h0);
      chk("t1_pc1", popped[1].pc, 64'h4);
      chk("t1_pc2", popped[2].pc, 64'h8);
      chk("t1_inst1", {32'd0, popped[1].inst}, 64'h00000000_C0DE0004);
    end

    // Decode stalled for 10 cycles, then released
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("t2_req_blocked", {63'd0, imem_req_valid}, 64'd0);
    chk("t2_head_pc", id_pc, 64'h0);
    chk("t2_pc_reg", imem_req_addr, 64'h8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("t2_pops", 64'(popped.size() >= 3), 64'd1);
    if (popped.size() >= 3) begin
      chk("t2_pc0", popped[0].pc, 64'h0);
      chk("t2_pc1", popped[1].pc, 64'h4);
      chk("t2_pc2", popped[2].pc, 64'h8);
    end

    // Memory ready toggling
    do_reset();
    for (int i = 0; i < 20; i++) step(i[0], 1'b1, 1'b0, '0);
    chk("t3_pops", 64'(popped.size() >= 3), 64'd1);
    foreach (popped[i]) chk("t3_seq", popped[i].pc, 64'(4 * i));

    // Redirect with two requests in flight, latency 3
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 64'h100);
    chk("t4_redir_no_req", {63'd0, last_req_valid}, 64'd0);
    for (int i = 0; i < 20 && popped.size() == 0; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("t4_got_pop", 64'(popped.size() > 0), 64'd1);
    if (popped.size() > 0) begin
      chk("t4_pc", popped[0].pc, 64'h100);
      chk("t4_inst", {32'd0, popped[0].inst}, 64'h00000000_C0DE0100);
    end

    // Redirect in the same cycle as a response and a decode pop
    do_reset();
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && eq.size() > 0) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, '0);
    end
    chk("t5_found_slot", {63'd0, found}, 64'd1);
    popped.delete();
    step(1'b1, 1'b1, 1'b1, 64'h200);
    chk("t5_no_pop", 64'(popped.size()), 64'd0);
    chk("t5_id_valid_after", {63'd0, id_valid}, 64'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("t5_pops", 64'(popped.size() > 0), 64'd1);
    if (popped.size() > 0) chk("t5_pc", popped[0].pc, 64'h200);

    // Misaligned redirect target
    do_reset();
    lat = 2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
    popped.delete();
    step(1'b1, 1'b1, 1'b1, 64'h102);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("t6_pops", 64'(popped.size() > 0), 64'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_count", 64'(popped.size()), 64'd1);
    chk("t6_no_req", {63'd0, imem_req_valid}, 64'd0);
    if (popped.size() > 0) begin
      chk("t6_pc", popped[0].pc, 64'h102);
      chk("t6_inst", {32'd0, popped[0].inst}, {32'd0, NOP});
      chk("t6_mis", {63'd0, popped[0].mis}, 64'd1);
    end
`else
    if (popped.size() > 0) begin
      chk("t6_pc", popped[0].pc, 64'h100);
      chk("t6_inst", {32'd0, popped[0].inst}, 64'h00000000_C0DE0100);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
